local_bias_seq: RTL and testbench

//  Clocked power-up sequencer and analog-testbus (ATB) scheduler for the local bias generator.
//  - Qualifies the 1.8 V, 0.8 V and ground rails and drives the bias power-down pin (pdb) only after the rails are stable.
//  - Holds bias_ready until the bias currents have settled.
//  - Grants ATB observation requests one at a time through a req/ack handshake.
//  - Sits between the digital control domain and the bias macro, and drives pdb and atb_ena[1:0].

---
 rtl/local_bias_pkg.sv | 16 +
 rtl/lb_rail_mon.sv | 14 +
 rtl/local_bias_seq.sv | 133 +++++++++++++
 tb/tb_local_bias_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/local_bias_pkg.sv
// local_bias_pkg: shared states, ATB modes and rail window constants for the local bias sequencer
package local_bias_pkg;
  typedef enum logic [2:0] {
    ST_OFF, ST_DEB, ST_SETTLE, ST_READY, ST_ATB_WAIT, ST_ATB_HOLD, ST_FAULT
  } lb_state_t;
  typedef enum logic [1:0] {
    ATB_OFF = 2'b00, ATB_1P8 = 2'b01, ATB_0P8 = 2'b10, ATB_CUR = 2'b11
  } atb_mode_t;
  localparam real VDDANA_1P8_REF = 1.8;
  localparam real VDDANA_0P8_REF = 0.8;
  localparam real VSSANA_MAX = 0.05;
  localparam real TOL = 0.05;
  function automatic logic in_win(input real v, input real lo, input real hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/lb_rail_mon.sv
// lb_rail_mon: combinational inclusive window check of the three analog rails
module lb_rail_mon
  import local_bias_pkg::*;
(
  input  real  vddana_1p8,
  input  real  vddana_0p8,
  input  real  vssana,
  output logic rails_ok
);
  always_comb
    rails_ok = in_win(vddana_1p8, VDDANA_1P8_REF * (1.0 - TOL), VDDANA_1P8_REF * (1.0 + TOL)) &&
               in_win(vddana_0p8, VDDANA_0P8_REF * (1.0 - TOL), VDDANA_0P8_REF * (1.0 + TOL)) &&
               in_win(vssana, -VSSANA_MAX, VSSANA_MAX);
endmodule

// File: rtl/local_bias_seq.sv
// local_bias_seq: power-up sequencer and ATB request scheduler for the local bias generator
module local_bias_seq
  import local_bias_pkg::*;
#(
  parameter int unsigned SUPPLY_DEB = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned ATB_SETTLE = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  real        vddana_1p8,
  input  real        vddana_0p8,
  input  real        vssana,
  input  logic       fault_clr,
  input  logic       atb_req,
  input  logic [1:0] atb_sel,
  output logic       pdb,
  output logic [1:0] atb_ena,
  output logic       atb_ack,
  output logic       bias_ready,
  output logic       fault,
  output logic [2:0] state_o
);
  localparam logic [CNT_W-1:0] DEB_LD = CNT_W'(SUPPLY_DEB - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ATB_LD = CNT_W'(ATB_SETTLE - 1);
  logic rails_ok;
  lb_state_t state_q, state_d;
  atb_mode_t atb_ena_q, atb_ena_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pdb_q, pdb_d, atb_ack_q, atb_ack_d, bias_ready_q, bias_ready_d, fault_q, fault_d;
  lb_rail_mon u_rail_mon (
    .vddana_1p8(vddana_1p8),
    .vddana_0p8(vddana_0p8),
    .vssana    (vssana),
    .rails_ok  (rails_ok)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pdb_d = pdb_q;
    atb_ena_d = atb_ena_q;
    atb_ack_d = 1'b0;
    bias_ready_d = bias_ready_q;
    fault_d = fault_q;
    if (pdb_q && !rails_ok) begin
      state_d = ST_FAULT;
      cnt_d = '0;
      pdb_d = 1'b0;
      atb_ena_d = ATB_OFF;
      bias_ready_d = 1'b0;
      fault_d = 1'b1;
    end else if (!en && state_q != ST_FAULT) begin
      state_d = ST_OFF;
      cnt_d = '0;
      pdb_d = 1'b0;
      atb_ena_d = ATB_OFF;
      bias_ready_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_DEB;
          cnt_d = DEB_LD;
        end
        ST_DEB: begin
          cnt_d = !rails_ok ? DEB_LD : cnt_q == '0 ? SET_LD : cnt_q - CNT_W'(1);
          if (rails_ok && cnt_q == '0) begin
            state_d = ST_SETTLE;
            pdb_d = 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_READY;
            bias_ready_d = 1'b1;
          end
        end
        ST_READY:
          if (atb_req && atb_sel != ATB_OFF) begin
            state_d = ST_ATB_WAIT;
            atb_ena_d = atb_mode_t'(atb_sel);
            cnt_d = ATB_LD;
          end
        ST_ATB_WAIT: begin
          cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_ATB_HOLD;
            atb_ack_d = 1'b1;
          end
        end
        ST_ATB_HOLD:
          if (!atb_req) begin
            state_d = ST_READY;
            atb_ena_d = ATB_OFF;
          end
        ST_FAULT:
          if (fault_clr && !en && rails_ok) begin
            state_d = ST_OFF;
            fault_d = 1'b0;
          end
        default: state_d = ST_OFF;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q <= '0;
      pdb_q <= 1'b0;
      atb_ena_q <= ATB_OFF;
      atb_ack_q <= 1'b0;
      bias_ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pdb_q <= pdb_d;
      atb_ena_q <= atb_ena_d;
      atb_ack_q <= atb_ack_d;
      bias_ready_q <= bias_ready_d;
      fault_q <= fault_d;
    end
  end
  assign pdb = pdb_q;
  assign atb_ena = atb_ena_q;
  assign atb_ack = atb_ack_q;
  assign bias_ready = bias_ready_q;
  assign fault = fault_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_local_bias_seq.sv
// tb_local_bias_seq: directed scenario bench for the local bias sequencer
module tb_local_bias_seq;
  import local_bias_pkg::*;
  logic clk = 1'b0, rst, en, fault_clr, atb_req;
  logic [1:0] atb_sel, atb_ena;
  logic pdb, atb_ack, bias_ready, fault;
  logic [2:0] state_o;
  real v18, v08, vss;
  int checks = 0, failures = 0;
  logic seen;
  local_bias_seq dut (
    .clk(clk), .rst(rst), .en(en),
    .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
    .fault_clr(fault_clr), .atb_req(atb_req), .atb_sel(atb_sel),
    .pdb(pdb), .atb_ena(atb_ena), .atb_ack(atb_ack),
    .bias_ready(bias_ready), .fault(fault), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (pdb !== 1'b0) begin failures++; $display("FAIL reset_pdb got=%0b exp=0", pdb); end checks++;
    if (atb_ena !== 2'b00) begin failures++; $display("FAIL reset_atb_ena got=%0b exp=00", atb_ena); end checks++;
    if (atb_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", atb_ack); end checks++;
    if (bias_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bias_ready); end checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", fault); end checks++;
    if (state_o !== ST_OFF) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_OFF); end checks++;
    rst = 1'b0;
  endtask
  task automatic test_power_up();
    en = 1'b1;
    repeat (4) tick();
    if (pdb !== 1'b0) begin failures++; $display("FAIL pu_pdb_early got=%0b exp=0", pdb); end checks++;
    if (state_o !== ST_DEB) begin failures++; $display("FAIL pu_state_deb got=%0d exp=%0d", state_o, ST_DEB); end checks++;
    tick();
    if (pdb !== 1'b1) begin failures++; $display("FAIL pu_pdb_rise got=%0b exp=1", pdb); end checks++;
    if (state_o !== ST_SETTLE) begin failures++; $display("FAIL pu_state_settle got=%0d exp=%0d", state_o, ST_SETTLE); end checks++;
    repeat (15) tick();
    if (bias_ready !== 1'b0) begin failures++; $display("FAIL pu_ready_early got=%0b exp=0", bias_ready); end checks++;
    tick();
    if (bias_ready !== 1'b1) begin failures++; $display("FAIL pu_ready_rise got=%0b exp=1", bias_ready); end checks++;
    if (state_o !== ST_READY) begin failures++; $display("FAIL pu_state_ready got=%0d exp=%0d", state_o, ST_READY); end checks++;
  endtask
  task automatic test_deb_glitch();
    en = 1'b0;
    tick();
    if (pdb !== 1'b0 || bias_ready !== 1'b0) begin failures++; $display("FAIL en_drop_clear got=%0b%0b exp=00", pdb, bias_ready); end checks++;
    en = 1'b1;
    tick();
    tick();
    v08 = 0.70;
    tick();
    if (state_o !== ST_DEB) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", state_o, ST_DEB); end checks++;
    v08 = 0.80;
    repeat (3) tick();
    if (pdb !== 1'b0) begin failures++; $display("FAIL glitch_pdb_early got=%0b exp=0", pdb); end checks++;
    tick();
    if (pdb !== 1'b1) begin failures++; $display("FAIL glitch_pdb_rise got=%0b exp=1", pdb); end checks++;
    repeat (16) tick();
    if (state_o !== ST_READY) begin failures++; $display("FAIL glitch_ready got=%0d exp=%0d", state_o, ST_READY); end checks++;
  endtask
  task automatic test_atb();
    atb_sel = 2'b10;
    atb_req = 1'b1;
    tick();
    if (atb_ena !== 2'b10) begin failures++; $display("FAIL atb_ena_set got=%0b exp=10", atb_ena); end checks++;
    if (state_o !== ST_ATB_WAIT) begin failures++; $display("FAIL atb_state_wait got=%0d exp=%0d", state_o, ST_ATB_WAIT); end checks++;
    seen = 1'b0;
    repeat (7) begin
      tick();
      if (atb_ack) seen = 1'b1;
    end
    if (seen !== 1'b0) begin failures++; $display("FAIL atb_ack_early got=%0b exp=0", seen); end checks++;
    tick();
    if (atb_ack !== 1'b1) begin failures++; $display("FAIL atb_ack_pulse got=%0b exp=1", atb_ack); end checks++;
    if (state_o !== ST_ATB_HOLD) begin failures++; $display("FAIL atb_state_hold got=%0d exp=%0d", state_o, ST_ATB_HOLD); end checks++;
    atb_sel = 2'b01;
    tick();
    if (atb_ack !== 1'b0) begin failures++; $display("FAIL atb_ack_single got=%0b exp=0", atb_ack); end checks++;
    if (atb_ena !== 2'b10) begin failures++; $display("FAIL atb_hold_ena got=%0b exp=10", atb_ena); end checks++;
    atb_req = 1'b0;
    tick();
    if (atb_ena !== 2'b00) begin failures++; $display("FAIL atb_release got=%0b exp=00", atb_ena); end checks++;
    if (state_o !== ST_READY) begin failures++; $display("FAIL atb_back_ready got=%0d exp=%0d", state_o, ST_READY); end checks++;
  endtask
  task automatic test_fault();
    atb_sel = 2'b11;
    atb_req = 1'b1;
    repeat (9) tick();
    if (state_o !== ST_ATB_HOLD || atb_ena !== 2'b11) begin failures++; $display("FAIL flt_pre got=%0d/%0b exp=%0d/11", state_o, atb_ena, ST_ATB_HOLD); end checks++;
    v18 = 1.60;
    tick();
    if (pdb !== 1'b0) begin failures++; $display("FAIL flt_pdb got=%0b exp=0", pdb); end checks++;
    if (atb_ena !== 2'b00) begin failures++; $display("FAIL flt_ena got=%0b exp=00", atb_ena); end checks++;
    if (fault !== 1'b1) begin failures++; $display("FAIL flt_fault got=%0b exp=1", fault); end checks++;
    if (bias_ready !== 1'b0) begin failures++; $display("FAIL flt_ready got=%0b exp=0", bias_ready); end checks++;
    v18 = 1.80;
    fault_clr = 1'b1;
    tick();
    if (state_o !== ST_FAULT || fault !== 1'b1) begin failures++; $display("FAIL flt_clr_en_high got=%0d/%0b exp=%0d/1", state_o, fault, ST_FAULT); end checks++;
    atb_req = 1'b0;
    en = 1'b0;
    v18 = 1.60;
    tick();
    if (state_o !== ST_FAULT) begin failures++; $display("FAIL flt_clr_rail_bad got=%0d exp=%0d", state_o, ST_FAULT); end checks++;
    v18 = 1.80;
    tick();
    if (state_o !== ST_OFF || fault !== 1'b0) begin failures++; $display("FAIL flt_exit got=%0d/%0b exp=%0d/0", state_o, fault, ST_OFF); end checks++;
    fault_clr = 1'b0;
  endtask
  task automatic test_reset_mid();
    en = 1'b1;
    repeat (8) tick();
    if (state_o !== ST_SETTLE) begin failures++; $display("FAIL rst_pre got=%0d exp=%0d", state_o, ST_SETTLE); end checks++;
    rst = 1'b1;
    tick();
    if (pdb !== 1'b0 || bias_ready !== 1'b0 || fault !== 1'b0 || atb_ena !== 2'b00 || state_o !== ST_OFF) begin
      failures++; $display("FAIL rst_mid got=pdb%0b rdy%0b flt%0b ena%0b st%0d exp=0 0 0 00 %0d", pdb, bias_ready, fault, atb_ena, state_o, ST_OFF);
    end checks++;
    rst = 1'b0;
    tick();
    if (state_o !== ST_DEB) begin failures++; $display("FAIL rst_restart got=%0d exp=%0d", state_o, ST_DEB); end checks++;
    repeat (3) tick();
    if (pdb !== 1'b0) begin failures++; $display("FAIL rst_pdb_early got=%0b exp=0", pdb); end checks++;
    tick();
    if (pdb !== 1'b1) begin failures++; $display("FAIL rst_pdb_rise got=%0b exp=1", pdb); end checks++;
    repeat (16) tick();
  endtask
  task automatic test_back_to_back();
    atb_req = 1'b1;
    atb_sel = 2'b00;
    repeat (3) tick();
    if (state_o !== ST_READY || atb_ena !== 2'b00 || atb_ack !== 1'b0) begin failures++; $display("FAIL sel00 got=%0d/%0b/%0b exp=%0d/00/0", state_o, atb_ena, atb_ack, ST_READY); end checks++;
    atb_sel = 2'b01;
    tick();
    if (state_o !== ST_ATB_WAIT || atb_ena !== 2'b01) begin failures++; $display("FAIL sel01 got=%0d/%0b exp=%0d/01", state_o, atb_ena, ST_ATB_WAIT); end checks++;
    repeat (3) tick();
    en = 1'b0;
    tick();
    if (state_o !== ST_OFF || pdb !== 1'b0 || atb_ena !== 2'b00 || bias_ready !== 1'b0) begin failures++; $display("FAIL abort got=%0d/%0b/%0b/%0b exp=%0d/0/00/0", state_o, pdb, atb_ena, bias_ready, ST_OFF); end checks++;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (atb_ack) seen = 1'b1;
    end
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_ack got=%0b exp=0", seen); end checks++;
    atb_req = 1'b0;
  endtask
  task automatic test_rail_window();
    en = 1'b1;
    repeat (21) tick();
    if (state_o !== ST_READY) begin failures++; $display("FAIL win_ready got=%0d exp=%0d", state_o, ST_READY); end checks++;
    v18 = 1.88;
    v08 = 0.77;
    vss = 0.04;
    repeat (2) tick();
    if (fault !== 1'b0 || state_o !== ST_READY) begin failures++; $display("FAIL win_inside got=%0b/%0d exp=0/%0d", fault, state_o, ST_READY); end checks++;
    v08 = 0.75;
    tick();
    if (fault !== 1'b1 || state_o !== ST_FAULT) begin failures++; $display("FAIL win_outside got=%0b/%0d exp=1/%0d", fault, state_o, ST_FAULT); end checks++;
    v08 = 0.80;
    vss = 0.0;
    en = 1'b0;
    fault_clr = 1'b1;
    tick();
    if (state_o !== ST_OFF || fault !== 1'b0) begin failures++; $display("FAIL win_clear got=%0d/%0b exp=%0d/0", state_o, fault, ST_OFF); end checks++;
    fault_clr = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    fault_clr = 1'b0;
    atb_req = 1'b0;
    atb_sel = 2'b00;
    v18 = 1.80;
    v08 = 0.80;
    vss = 0.0;
    test_reset();
    test_power_up();
    test_deb_glitch();
    test_atb();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_rail_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
